// File: rtl/booth_mult_ctrl.sv
// rtl/booth_mult_ctrl.sv - radix-2 Booth multiplier sequencing controller
// Optional feature macro: BOOTH_EARLY_SKIP_EN (skip ARITH when {Q[0],q} is 00 or 11)
`timescale 1ns/1ps
module booth_mult_ctrl #(
    parameter int data_Width = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [data_Width-1:0]     multiplicand,
    input  logic [data_Width-1:0]     multiplier,
    output logic                      busy,
    output logic                      done,
    output logic [2*data_Width-1:0]   product,
    output logic                      alu_en,
    output logic [1:0]                alu_func,
    output logic [data_Width-1:0]     alu_ac,
    output logic [data_Width-1:0]     alu_q,
    output logic                      alu_q0,
    output logic [data_Width-1:0]     alu_multiplicand,
    input  logic                      alu_valid,
    input  logic [2*data_Width:0]     alu_out
);

    localparam int W  = data_Width;
    localparam int CW = $clog2(W) + 1;

    localparam logic [1:0] FUNC_SUB = 2'b00;
    localparam logic [1:0] FUNC_ADD = 2'b01;
    localparam logic [1:0] FUNC_ASR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARITH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [W-1:0]      ac_q;
    logic [W-1:0]      qr_q;
    logic              q0_q;
    logic [W-1:0]      m_q;
    logic [CW-1:0]     cnt_q;
    logic              ovf_q;
    logic              busy_q;
    logic              done_q;
    logic [2*W-1:0]    product_q;
    logic              alu_en_q;
    logic [1:0]        alu_func_q;

    logic [W-1:0]      arith_res_d;
    logic              ovf_d;
    logic [2*W:0]      shift_d;
    logic [CW-1:0]     cnt_dec_d;
    logic [2:0]        idle_ctl_d;
    logic [2:0]        iter_ctl_d;

    // Returns {alu_en, alu_func} for the add/subtract step of one Booth iteration.
    function automatic logic [2:0] arith_ctl(input logic q_lsb, input logic q_ext);
        case ({q_lsb, q_ext})
            2'b10:   arith_ctl = {1'b1, FUNC_SUB};
            2'b01:   arith_ctl = {1'b1, FUNC_ADD};
            default: arith_ctl = {1'b0, FUNC_SUB};
        endcase
    endfunction

    // The ALU works on W-bit AC and loses the sign when AC+-M overflows (e.g. M = -2^(W-1)).
    // Remembering the overflow and repairing the shifted-in sign bit keeps the product exact.
    always_comb begin
        arith_res_d = alu_out[2*W:W+1];
        ovf_d       = 1'b0;
        if (alu_func_q == FUNC_SUB)
            ovf_d = (ac_q[W-1] != m_q[W-1]) && (arith_res_d[W-1] != ac_q[W-1]);
        else
            ovf_d = (ac_q[W-1] == m_q[W-1]) && (arith_res_d[W-1] != ac_q[W-1]);
        shift_d       = alu_out;
        shift_d[2*W]  = alu_out[2*W] ^ ovf_q;
        cnt_dec_d     = cnt_q - CW'(1);
        idle_ctl_d    = arith_ctl(multiplier[0], 1'b0);
        iter_ctl_d    = arith_ctl(shift_d[1], shift_d[0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ac_q       <= '0;
            qr_q       <= '0;
            q0_q       <= 1'b0;
            m_q        <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            product_q  <= '0;
            alu_en_q   <= 1'b0;
            alu_func_q <= FUNC_SUB;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        m_q    <= multiplicand;
                        qr_q   <= multiplier;
                        ac_q   <= '0;
                        q0_q   <= 1'b0;
                        cnt_q  <= CW'(W);
                        ovf_q  <= 1'b0;
                        busy_q <= 1'b1;
`ifdef BOOTH_EARLY_SKIP_EN
                        if (!idle_ctl_d[2]) begin
                            state_q    <= SHIFT;
                            alu_en_q   <= 1'b1;
                            alu_func_q <= FUNC_ASR;
                        end else begin
                            state_q    <= ARITH;
                            alu_en_q   <= idle_ctl_d[2];
                            alu_func_q <= idle_ctl_d[1:0];
                        end
`else
                        state_q    <= ARITH;
                        alu_en_q   <= idle_ctl_d[2];
                        alu_func_q <= idle_ctl_d[1:0];
`endif
                    end
                end
                ARITH: begin
                    if (!alu_en_q) begin
                        state_q    <= SHIFT;
                        ovf_q      <= 1'b0;
                        alu_en_q   <= 1'b1;
                        alu_func_q <= FUNC_ASR;
                    end else if (alu_valid) begin
                        ac_q       <= arith_res_d;
                        ovf_q      <= ovf_d;
                        state_q    <= SHIFT;
                        alu_en_q   <= 1'b1;
                        alu_func_q <= FUNC_ASR;
                    end
                end
                SHIFT: begin
                    if (alu_valid) begin
                        {ac_q, qr_q, q0_q} <= shift_d;
                        ovf_q <= 1'b0;
                        cnt_q <= cnt_dec_d;
                        if (cnt_dec_d == '0) begin
                            state_q    <= DONE;
                            product_q  <= shift_d[2*W:1];
                            done_q     <= 1'b1;
                            alu_en_q   <= 1'b0;
                            alu_func_q <= FUNC_SUB;
`ifdef BOOTH_EARLY_SKIP_EN
                        end else if (!iter_ctl_d[2]) begin
                            state_q    <= SHIFT;
                            alu_en_q   <= 1'b1;
                            alu_func_q <= FUNC_ASR;
`endif
                        end else begin
                            state_q    <= ARITH;
                            alu_en_q   <= iter_ctl_d[2];
                            alu_func_q <= iter_ctl_d[1:0];
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    alu_en_q   <= 1'b0;
                    alu_func_q <= FUNC_SUB;
                end
            endcase
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign product          = product_q;
    assign alu_en           = alu_en_q;
    assign alu_func         = alu_func_q;
    assign alu_ac           = ac_q;
    assign alu_q            = qr_q;
    assign alu_q0           = q0_q;
    assign alu_multiplicand = m_q;

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// tb/tb_booth_mult_ctrl.sv - directed self-checking bench for booth_mult_ctrl
// Expected cycles follow BOOTH_EARLY_SKIP_EN when that macro is defined.
`timescale 1ns/1ps
module tb_booth_mult_ctrl;

    localparam int W = 4;

`ifdef BOOTH_EARLY_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [W-1:0]     multiplicand;
    logic [W-1:0]     multiplier;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;
    logic             alu_en;
    logic [1:0]       alu_func;
    logic [W-1:0]     alu_ac;
    logic [W-1:0]     alu_q;
    logic             alu_q0;
    logic [W-1:0]     alu_multiplicand;
    logic             alu_valid;
    logic [2*W:0]     alu_out;
    logic [W-1:0]     alu_sum;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    booth_mult_ctrl #(.data_Width(W)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .multiplicand     (multiplicand),
        .multiplier       (multiplier),
        .busy             (busy),
        .done             (done),
        .product          (product),
        .alu_en           (alu_en),
        .alu_func         (alu_func),
        .alu_ac           (alu_ac),
        .alu_q            (alu_q),
        .alu_q0           (alu_q0),
        .alu_multiplicand (alu_multiplicand),
        .alu_valid        (alu_valid),
        .alu_out          (alu_out)
    );

    // Plain W-bit Booth ALU: wrapping add/subtract, arithmetic shift of {AC,Q,q}.
    always_comb begin
        alu_sum = (alu_func == 2'b01) ? (alu_ac + alu_multiplicand) : (alu_ac - alu_multiplicand);
        alu_out = '0;
        if (alu_func == 2'b10)
            alu_out = $signed({alu_ac, alu_q, alu_q0}) >>> 1;
        else if (alu_func != 2'b11)
            alu_out = {alu_sum, {(W+1){1'b0}}};
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q,
                          input logic [2*W-1:0] exp_prod, input int exp_done,
                          input int stall_at, input int stall_len,
                          input int restart_at, input string tag);
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = ~m;
        multiplier   = ~q;
        for (int cyc = 1; cyc <= exp_done + 2; cyc++) begin
            alu_valid = !(cyc >= stall_at && cyc < stall_at + stall_len);
            start     = (cyc == restart_at);
            #1;
            chk($sformatf("%s_done_c%0d", tag, cyc), 16'(done), 16'(cyc == exp_done));
            chk($sformatf("%s_busy_c%0d", tag, cyc), 16'(busy), 16'(cyc <= exp_done));
            if (cyc >= stall_at && cyc < stall_at + stall_len) begin
                chk($sformatf("%s_stall_en_c%0d", tag, cyc), 16'(alu_en), 16'h1);
                chk($sformatf("%s_stall_func_c%0d", tag, cyc), 16'(alu_func), 16'h2);
                chk($sformatf("%s_stall_ac_c%0d", tag, cyc), 16'(alu_ac), 16'hD);
                chk($sformatf("%s_stall_q_c%0d", tag, cyc), 16'(alu_q), 16'h7);
                chk($sformatf("%s_stall_q0_c%0d", tag, cyc), 16'(alu_q0), 16'h0);
            end
            if (cyc == exp_done)
                chk($sformatf("%s_product", tag), 16'(product), 16'(exp_prod));
            @(posedge clk);
            #1;
        end
        alu_valid = 1'b1;
        start     = 1'b0;
        chk($sformatf("%s_product_held", tag), 16'(product), 16'(exp_prod));
        chk($sformatf("%s_idle_alu_en", tag), 16'(alu_en), 16'h0);
    endtask

    initial begin
        bit seen_done;
        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        alu_valid    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_done", 16'(done), 16'h0);
        chk("rst_product", 16'(product), 16'h0);
        chk("rst_alu_en", 16'(alu_en), 16'h0);
        chk("rst_alu_func", 16'(alu_func), 16'h0);
        chk("rst_alu_ac", 16'(alu_ac), 16'h0);
        chk("rst_alu_q", 16'(alu_q), 16'h0);
        chk("rst_alu_q0", 16'(alu_q0), 16'h0);
        chk("rst_alu_m", 16'(alu_multiplicand), 16'h0);
        @(negedge clk);
        rst = 1'b0;

        run_op(4'd3, 4'hE, 8'hFA, SKIP ? 6 : 9, 0, 0, 0, "m3_qm2");
        run_op(4'h8, 4'h8, 8'h40, SKIP ? 6 : 9, 0, 0, 0, "m8_q8");
        run_op(4'h8, 4'h7, 8'hC8, SKIP ? 7 : 9, 0, 0, 0, "mm8_q7");
        run_op(4'h7, 4'h7, 8'h31, SKIP ? 7 : 9, 0, 0, 0, "m7_q7");
        run_op(4'h0, 4'h5, 8'h00, 9,            0, 0, 0, "m0_q5");
        run_op(4'h3, 4'h0, 8'h00, SKIP ? 5 : 9, 0, 0, 0, "m3_q0");
        run_op(4'd3, 4'hE, 8'hFA, SKIP ? 9 : 12, SKIP ? 3 : 4, 3, 0, "stall");
        run_op(4'h7, 4'h7, 8'h31, SKIP ? 7 : 9, 0, 0, 4, "restart");

        // Abort an operation with reset raised during cycle 5.
        @(negedge clk);
        multiplicand = 4'd3;
        multiplier   = 4'hE;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        chk("abort_done_in_rst", 16'(done), 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", 16'(busy), 16'h0);
        chk("abort_done", 16'(done), 16'h0);
        chk("abort_product", 16'(product), 16'h0);
        chk("abort_alu_en", 16'(alu_en), 16'h0);
        chk("abort_alu_ac", 16'(alu_ac), 16'h0);
        seen_done = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done = 1'b1;
        end
        chk("abort_no_done", 16'(seen_done), 16'h0);

        run_op(4'h8, 4'h7, 8'hC8, SKIP ? 7 : 9, 0, 0, 0, "after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/booth_mult_ctrl.md
# booth_mult_ctrl

Sequencing controller for the radix-2 Booth multiplier datapath. Holds the AC/Q/q/M working registers and the iteration counter. Each iteration drives the combinational Booth ALU through one optional add/subtract step and one arithmetic right shift, then returns the signed 2W-bit product with a start/done handshake. Sits between the multiplier's user-facing request port and the ALU instance.

## Interface
- `data_Width`, default 4: operand width W (W ≥ 2); the product is 2W bits.
- `clk`  in  1  single clock; rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request; sampled only in IDLE.
- `multiplicand`  in  W  signed M; captured when start is accepted.
- `multiplier`  in  W  signed Q; captured when start is accepted.
- `busy`  out  1  high from the cycle after acceptance through the DONE cycle.
- `done`  out  1  one-cycle pulse; product valid in the same cycle.
- `product`  out  2W  signed result {AC,Q}; registered and held until the next acceptance.
- `alu_en`  out  1  ALU enable.
- `alu_func`  out  2  ALU operation: 00 = AC−M, 01 = AC+M, 10 = arithmetic shift right of {AC,Q,q}.
- `alu_ac`  out  W  current AC register.
- `alu_q`  out  W  current Q register.
- `alu_q0`  out  1  current q (extra LSB) register.
- `alu_multiplicand`  out  W  current M register.
- `alu_valid`  in  1  ALU result valid.
- `alu_out`  in  2W+1  ALU result. For func 00/01 only [2W:W+1] is meaningful; the other bits are zero.

## Operation
- States: IDLE, ARITH, SHIFT, DONE.
- IDLE, start=1: load M←multiplicand, Q←multiplier, AC←0, q←0, cnt←W; go to ARITH. If start=0, stay in IDLE.
- ARITH: decode {Q[0],q}.
  - 10: alu_en=1, func=00.
  - 01: alu_en=1, func=01.
  - When alu_valid=1: AC←alu_out[2W:W+1]; Q, q and M are unchanged; go to SHIFT.
  - 00 or 11: alu_en=0, AC holds; go to SHIFT unconditionally.
- SHIFT: alu_en=1, func=10.
  - When alu_valid=1: {AC,Q,q}←alu_out; cnt←cnt−1.
  - If the decremented cnt is 0, go to DONE; otherwise go to ARITH.
- Stall rule: in any state with alu_en=1 and alu_valid=0, state and all registers hold, and alu_en/func stay stable.
- DONE: product←{AC,Q}, registered on entry so it is valid during DONE. done=1 for this cycle, busy=1. Next state is IDLE.
- start while busy is ignored; there is no queueing.
- Arithmetic: AC±M wraps modulo 2^W, as in standard Booth. The 2W-bit result is exact for all signed inputs, including −2^(W−1)·−2^(W−1).
- cnt width is clog2(W)+1.
- Outside ARITH and SHIFT: alu_en=0, func=00.

## Timing
- Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, product=0, alu_en=0, alu_func=00; AC, Q, q, M and cnt cleared.
- Reset mid-operation aborts the operation immediately. No done is produced.
- Without stalls, start accepted at edge 0:
  - ARITH occupies cycle 1.
  - Iteration k (k=0..W−1) occupies cycles 2k+1 (ARITH) and 2k+2 (SHIFT).
  - DONE is cycle 2W+1; fixed latency is 2W+1 cycles.
  - IDLE is cycle 2W+2; a new start can be accepted at the end of that cycle.
- Each stalled cycle adds exactly one cycle of latency.
- done never asserts while rst=1.

## Configuration
- `BOOTH_EARLY_SKIP_EN` defined: when {Q[0],q} is 00 or 11 at entry to an iteration, ARITH is skipped. The state goes directly to SHIFT: from IDLE on acceptance, or from SHIFT when cnt remains nonzero. Latency becomes variable: 1 + W + (number of add/sub iterations) cycles.
- `BOOTH_EARLY_SKIP_EN` undefined: fixed 2W+1 latency as specified above.
- The product value is identical in both builds.

## Test plan
- W=4, M=3, Q=−2 (1110), alu_valid tied 1 → done at cycle 9, product=8'hFA (−6), busy high cycles 1–9.
- M=−8, Q=−8 → product=8'h40. M=−8, Q=7 → product=8'hC8. M=7, Q=7 → product=8'h31.
- M=0, Q=5 → product=0. With `BOOTH_EARLY_SKIP_EN`: M=3, Q=0 → done at cycle 5 (no ARITH cycles).
- Drive alu_valid=0 for 3 cycles during the second SHIFT → registers and alu_func hold, done delayed to cycle 12, product still correct.
- Pulse start again at cycle 4 of an operation → ignored. Result and done timing unchanged; the next start is accepted only after done.
- Assert rst at cycle 5 → cycle 6 shows state IDLE, busy=0, product=0, no done pulse. A fresh start then completes normally.
